// File: rtl/sobolrng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sobolrng_pkg
// Description : Shared Sobol RNG word width, index width and value type.
// Revision    : 1.0  initial release
// ============================================================================
package sobolrng_pkg;
    localparam int c_BITWIDTH    = 4;
    localparam int c_LOGBITWIDTH = 2;

    typedef logic [c_BITWIDTH-1:0] sobol_t;
endpackage
`default_nettype wire

// File: rtl/sobolrng_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : sobolrng_sched_if
// Description : Channel request/clear and acknowledged-value bundle for the scheduler.
// Revision    : 1.0  initial release
// ============================================================================
interface sobolrng_sched_if #(
    parameter int BITWIDTH = 4,
    parameter int NUM_CH   = 4,
    parameter int LOGCH    = 2
);
    logic [NUM_CH-1:0]            iReq;
    logic [NUM_CH-1:0]            iClr;
    logic [BITWIDTH*BITWIDTH-1:0] iDirVec;
    logic [NUM_CH-1:0]            oAck;
    logic [LOGCH-1:0]             oChIdx;
    logic [BITWIDTH-1:0]          oSobol;

    modport master (output iReq, output iClr, output iDirVec,
                    input  oAck, input  oChIdx, input  oSobol);
    modport slave  (input  iReq, input  iClr, input  iDirVec,
                    output oAck, output oChIdx, output oSobol);
endinterface
`default_nettype wire

// File: rtl/lsz.sv
`default_nettype none
// ============================================================================
// Module      : lsz
// Description : Index of the least significant zero bit of the counter word.
// Revision    : 1.0  initial release
// ============================================================================
module lsz #(
    parameter int BITWIDTH    = 4,
    parameter int LOGBITWIDTH = 2
) (
    input  wire logic [BITWIDTH-1:0]    iGray,
    output logic      [LOGBITWIDTH-1:0] oLszIdx
);
    // Scan from the top down so the lowest zero position is the last one written.
    always_comb begin
        oLszIdx = '0;
        for (int i = BITWIDTH - 1; i >= 0; i--) begin
            if (!iGray[i]) begin
                oLszIdx = LOGBITWIDTH'(i);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/sobolrng_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : sobolrng_rr_arb
// Description : Round-robin arbiter; priority starts just above the last grant.
// Revision    : 1.0  initial release
// ============================================================================
module sobolrng_rr_arb #(
    parameter int NUM_CH = 4,
    parameter int LOGCH  = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [NUM_CH-1:0] iReq,
    output logic      [NUM_CH-1:0] oGrant,
    output logic      [LOGCH-1:0]  oGrantIdx,
    output logic                   oValid
);
    logic [LOGCH-1:0] r_ptr;

    // NUM_CH is a power of two, so the LOGCH-bit add wraps the search naturally.
    always_comb begin
        logic [LOGCH-1:0] cand;
        oGrantIdx = '0;
        oValid    = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = r_ptr + LOGCH'(i);
            if (!oValid && iReq[cand]) begin
                oValid    = 1'b1;
                oGrantIdx = cand;
            end
        end
    end

    assign oGrant = oValid ? (NUM_CH'(1) << oGrantIdx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (oValid) begin
            r_ptr <= oGrantIdx + LOGCH'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/sobolrng_sched.sv
`default_nettype none
// ============================================================================
// Module      : sobolrng_sched
// Description : Time-shares one lsz/XOR Sobol datapath among NUM_CH channels.
// Revision    : 1.0  initial release
// ============================================================================
module sobolrng_sched
    import sobolrng_pkg::*;
#(
    parameter int BITWIDTH    = c_BITWIDTH,
    parameter int LOGBITWIDTH = c_LOGBITWIDTH,
    parameter int NUM_CH      = 4,
    parameter int LOGCH       = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    sobolrng_sched_if.slave  bus
);
    logic [BITWIDTH-1:0]    r_cnt [NUM_CH];
    logic [BITWIDTH-1:0]    r_sob [NUM_CH];
    logic [NUM_CH-1:0]      r_ack;
    logic [LOGCH-1:0]       r_chIdx;
    logic [BITWIDTH-1:0]    r_sobol;

    logic [NUM_CH-1:0]      w_elig;
    logic [NUM_CH-1:0]      w_grantOh;
    logic [LOGCH-1:0]       w_grantIdx;
    logic                   w_grantVld;
    logic [BITWIDTH-1:0]    w_selCnt;
    logic [BITWIDTH-1:0]    w_selSob;
    logic [LOGBITWIDTH-1:0] w_lszIdx;
    logic [BITWIDTH-1:0]    w_dirVec;
    logic [BITWIDTH-1:0]    w_nextSob;

    // A channel being cleared never competes, so clear always beats grant.
    assign w_elig = bus.iReq & ~bus.iClr;

    sobolrng_rr_arb #(
        .NUM_CH (NUM_CH),
        .LOGCH  (LOGCH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .iReq      (w_elig),
        .oGrant    (w_grantOh),
        .oGrantIdx (w_grantIdx),
        .oValid    (w_grantVld)
    );

    assign w_selCnt = r_cnt[w_grantIdx];
    assign w_selSob = r_sob[w_grantIdx];

    lsz #(
        .BITWIDTH    (BITWIDTH),
        .LOGBITWIDTH (LOGBITWIDTH)
    ) u_lsz (
        .iGray   (w_selCnt),
        .oLszIdx (w_lszIdx)
    );

    assign w_dirVec  = bus.iDirVec[int'(w_lszIdx)*BITWIDTH +: BITWIDTH];
    // The all-ones count ends the period; restart rather than trust lsz there.
    assign w_nextSob = (&w_selCnt) ? '0 : (w_selSob ^ w_dirVec);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        always_ff @(posedge clk) begin
            if (rst || bus.iClr[c]) begin
                r_cnt[c] <= '0;
                r_sob[c] <= '0;
            end else if (w_grantVld && (w_grantIdx == LOGCH'(c))) begin
                r_cnt[c] <= r_cnt[c] + BITWIDTH'(1);
                r_sob[c] <= w_nextSob;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack   <= '0;
            r_chIdx <= '0;
            r_sobol <= '0;
        end else begin
            r_ack <= w_grantOh;
            if (w_grantVld) begin
                r_chIdx <= w_grantIdx;
                r_sobol <= w_selSob;
            end
        end
    end

    assign bus.oAck   = r_ack;
    assign bus.oChIdx = r_chIdx;
    assign bus.oSobol = r_sobol;
endmodule
`default_nettype wire

// File: tb/tb_sobolrng_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobolrng_sched
// Description : Directed and randomized checks of sobolrng_sched against a Gray-code Sobol model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sobolrng_sched;
    localparam int BW = 4;
    localparam int NC = 4;
    localparam int LC = 2;
    localparam int PERIOD = 1 << BW;

    logic clk;
    logic rst;
    int   checks;
    int   passed;

    int   mIdx [NC];
    int   mLast;
    int   vec  [BW];
    int   expAck, expCh, expSob;

    sobolrng_sched_if #(.BITWIDTH(BW), .NUM_CH(NC), .LOGCH(LC)) bus ();

    sobolrng_sched #(
        .BITWIDTH    (BW),
        .LOGBITWIDTH (2),
        .NUM_CH      (NC),
        .LOGCH       (LC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // n-th Sobol point: XOR of the direction vectors selected by the Gray code of n.
    function automatic int sobolAt(input int n);
        int g;
        int r;
        g = n ^ (n >> 1);
        r = 0;
        for (int j = 0; j < BW; j++) begin
            if ((g >> j) & 1) r = r ^ vec[j];
        end
        return r;
    endfunction

    task automatic setVec(input int v0, input int v1, input int v2, input int v3);
        vec[0] = v0; vec[1] = v1; vec[2] = v2; vec[3] = v3;
        bus.iDirVec = {4'(v3), 4'(v2), 4'(v1), 4'(v0)};
    endtask

    task automatic modelStep(input int req, input int clr, input bit doRst);
        int g;
        if (doRst) begin
            for (int c = 0; c < NC; c++) mIdx[c] = 0;
            mLast  = NC - 1;
            expAck = 0; expCh = 0; expSob = 0;
            return;
        end
        g = -1;
        for (int k = 1; k <= NC; k++) begin
            int c;
            c = (mLast + k) % NC;
            if (g < 0 && ((req >> c) & 1) && !((clr >> c) & 1)) g = c;
        end
        if (g >= 0) begin
            expAck  = 1 << g;
            expCh   = g;
            expSob  = sobolAt(mIdx[g]);
            mIdx[g] = (mIdx[g] + 1) % PERIOD;
            mLast   = g;
        end else begin
            expAck = 0;
        end
        for (int c = 0; c < NC; c++) begin
            if ((clr >> c) & 1) mIdx[c] = 0;
        end
    endtask

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic cycle(input int req, input int clr, input bit doRst);
        bus.iReq = NC'(req);
        bus.iClr = NC'(clr);
        rst      = doRst;
        modelStep(req, clr, doRst);
        @(posedge clk);
        #1;
        check("ack", int'(bus.oAck), expAck);
        check("chidx", int'(bus.oChIdx), expCh);
        check("sobol", int'(bus.oSobol), expSob);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        bus.iReq = '0;
        bus.iClr = '0;
        rst = 1'b1;
        setVec(8, 4, 2, 1);

        // Reset state
        cycle(0, 0, 1'b1);
        cycle(0, 0, 1'b1);

        // Single requester: 0,8,12,4,6,14,10,2
        for (int i = 0; i < 8; i++) cycle(4'b0001, 0, 1'b0);

        // All requesters round-robin
        cycle(0, 0, 1'b1);
        for (int i = 0; i < 12; i++) cycle(4'b1111, 0, 1'b0);

        // Wrap after 16 values
        cycle(0, 0, 1'b1);
        for (int i = 0; i < 18; i++) cycle(4'b0001, 0, 1'b0);

        // Clear on ch1 after three values
        cycle(0, 0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(4'b0010, 0, 1'b0);
        cycle(4'b0010, 4'b0010, 1'b0);
        cycle(4'b0010, 0, 1'b0);
        cycle(4'b0010, 0, 1'b0);

        // Alternating ch0/ch2, and clearing every requester
        cycle(4'b0001, 0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(4'b0101, 0, 1'b0);
        cycle(4'b0101, 4'b0101, 1'b0);
        cycle(0, 0, 1'b0);

        // Reset mid-stream
        for (int i = 0; i < 5; i++) cycle(4'b1111, 0, 1'b0);
        cycle(4'b1111, 0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(4'b1111, 0, 1'b0);

        // Randomized traffic with standard vectors
        for (int i = 0; i < 300; i++) begin
            cycle(int'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : 0,
                  $urandom_range(0, 63) == 0);
        end

        // Randomized traffic with random direction vectors
        cycle(0, 0, 1'b1);
        setVec(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        cycle(0, 0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            cycle(int'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : 0,
                  1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire
